// File: rtl/seq_multiplier32.sv
// seq_multiplier32: multi-cycle 32x32->64 shift-add multiplier, unsigned or
// signed, with start/busy/done handshake.
//   clk, rst_n (async, active-low)
//   start, multiplicand, multiplier, s : request; sampled only in IDLE
//   product, ovf : registered result, written at FIX and held
//   busy : high from the cycle after acceptance through DONE
//   done : one-cycle pulse when product first shows the new result
module seq_multiplier32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    input  logic        s,
    output logic [63:0] product,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sign_q, sign_d;
    logic        smode_q, smode_d;
    logic [63:0] product_q, product_d;
    logic        ovf_q, ovf_d;

    logic [31:0] mag_a, mag_b;
    logic [32:0] sum;
    logic [63:0] full, res;
    logic        res_ovf;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = CALC;
            CALC: if (cnt_q == 5'd31) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded straight from the state register
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    assign product = product_q;
    assign ovf     = ovf_q;

    // Operand magnitudes; 0x80000000 negates to itself, which is the
    // correct unsigned magnitude.
    assign mag_a = (s && multiplicand[31]) ? (~multiplicand + 32'd1)
                                           : multiplicand;
    assign mag_b = (s && multiplier[31]) ? (~multiplier + 32'd1)
                                         : multiplier;

    // Single 33-bit adder shared by all iterations
    assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : 33'd0);

    assign full = {hi_q, lo_q};
    assign res  = sign_q ? (~full + 64'd1) : full;
    assign res_ovf = smode_q ? (res[63:32] != {32{res[31]}})
                             : (res[63:32] != 32'd0);

    // Datapath next-state
    always_comb begin
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        smode_d   = smode_q;
        product_d = product_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = s & (multiplicand[31] ^ multiplier[31]);
                    smode_d = s;
                    mcand_d = mag_a;
                    lo_d    = mag_b;
                    hi_d    = 32'd0;
                    cnt_d   = 5'd0;
                end
            end
            CALC: begin
                // {c,sum,lo} >> 1
                hi_d  = sum[32:1];
                lo_d  = {sum[0], lo_q[31:1]};
                cnt_d = cnt_q + 5'd1;
            end
            FIX: begin
                product_d = res;
                ovf_d     = res_ovf;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            smode_q   <= 1'b0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            smode_q   <= smode_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_seq_multiplier32.sv
// tb_seq_multiplier32: table vectors, hand-written corner sequences and
// random operands against an arithmetic reference model.
module tb_seq_multiplier32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        s_i;
    logic [63:0] product;
    logic        busy;
    logic        done;
    logic        ovf;

    int n_checks;
    int n_fail;

    seq_multiplier32 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .s            (s_i),
        .product      (product),
        .busy         (busy),
        .done         (done),
        .ovf          (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic [63:0] p;
        logic        o;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the interpreted operands.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sg, output logic [63:0] p,
                                  output logic o);
        longint sp;
        longint lim;
        lim = 64'sd2147483647;
        if (sg) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            p  = sp;
            o  = (sp > lim) || (sp < -lim - 1);
        end else begin
            p = {32'd0, a} * {32'd0, b};
            o = (p > 64'h0000_0000_FFFF_FFFF);
        end
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic sg, output logic [63:0] p,
                         output logic o, output int done_at,
                         output int busy_n, output int done_n,
                         output int glitch);
        logic [63:0] prev;
        p = '0; o = 1'b0; done_at = 0; busy_n = 0; done_n = 0; glitch = 0;
        @(negedge clk);
        prev  = product;
        start = 1'b1; mcand = a; mplier = b; s_i = sg;
        @(negedge clk);
        // Changes after acceptance must have no effect
        start = 1'b0; mcand = $urandom; mplier = $urandom; s_i = ~sg;
        for (int k = 1; k <= 40; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) begin
                    done_at = k;
                    p = product;
                    o = ovf;
                end
            end else if (done_at == 0 && product !== prev) begin
                glitch++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [63:0] p, ep;
        logic        o, eo;
        int          dat, bn, dn, gl, nd;
        logic [31:0] ra, rb;
        logic        rs;

        n_checks = 0; n_fail = 0;
        start = 1'b0; mcand = '0; mplier = '0; s_i = 1'b0;

        vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
                    64'hFFFF_FFFE_0000_0001, 1'b1};
        vecs[1] = '{32'hFFFF_FFF9, 32'd3, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
        vecs[2] = '{32'hFFFF_FFF9, 32'hFFFF_FFFD, 1'b1, 64'd21, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1,
                    64'h4000_0000_0000_0000, 1'b1};
        vecs[4] = '{32'h8000_0000, 32'd1, 1'b1,
                    64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[5] = '{32'd0, 32'h8000_0000, 1'b1, 64'd0, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'd2, 1'b0, 64'h1_0000_0000, 1'b1};
        vecs[7] = '{32'd5, 32'd5, 1'b0, 64'd25, 1'b0};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_product", product, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_ovf", {63'd0, ovf}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sg, p, o, dat, bn, dn, gl);
            chk($sformatf("vec%0d_product", i), p, vecs[i].p);
            chk($sformatf("vec%0d_ovf", i), {63'd0, o}, {63'd0, vecs[i].o});
            chk($sformatf("vec%0d_done_cycle", i), 64'(dat), 64'd34);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(bn), 64'd34);
            chk($sformatf("vec%0d_done_pulses", i), 64'(dn), 64'd1);
            chk($sformatf("vec%0d_no_glitch", i), 64'(gl), 64'd0);
        end
        chk("hold_after_done", product, 64'd25);

        // Start re-pulse mid-operation must be ignored
        @(negedge clk);
        start = 1'b1; mcand = 32'd6; mplier = 32'd7; s_i = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; mcand = 32'd0; mplier = 32'd0; s_i = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0; dat = 0; p = '0;
        for (int k = 11; k <= 80; k++) begin
            if (done) begin
                nd++;
                if (dat == 0) begin
                    dat = k;
                    p = product;
                end
            end
            @(negedge clk);
        end
        chk("midstart_done_pulses", 64'(nd), 64'd1);
        chk("midstart_done_cycle", 64'(dat), 64'd34);
        chk("midstart_product", p, 64'd42);

        // Reset in the cycle between E10 and E11
        @(negedge clk);
        start = 1'b1; mcand = 32'd3; mplier = 32'd3; s_i = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_product", product, 64'd0);
        chk("abort_ovf", {63'd0, ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) nd++;
            @(negedge clk);
        end
        chk("abort_no_late_activity", 64'(nd), 64'd0);
        do_op(32'd5, 32'd5, 1'b0, p, o, dat, bn, dn, gl);
        chk("recover_product", p, 64'd25);
        chk("recover_ovf", {63'd0, o}, 64'd0);
        chk("recover_done_cycle", 64'(dat), 64'd34);

        // Random operands against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra = 32'($urandom_range(0, 65535));
            if (i % 4 == 2) rb = 32'($urandom_range(0, 65535));
            if (i % 4 == 3) begin
                ra = 32'($urandom_range(0, 65535));
                rb = -32'($urandom_range(0, 65535));
            end
            model(ra, rb, rs, ep, eo);
            do_op(ra, rb, rs, p, o, dat, bn, dn, gl);
            chk($sformatf("rand%0d_product", i), p, ep);
            chk($sformatf("rand%0d_ovf", i), {63'd0, o}, {63'd0, eo});
            chk($sformatf("rand%0d_done_cycle", i), 64'(dat), 64'd34);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
